isp_ee_v2: RTL and testbench

- Second-generation luma edge enhancer for the ISP lite pipeline, placed after colour conversion and before output scaling/DMA.
- Streams YUV pixels under href/vsync timing. Builds a 3x3 luma window from two line buffers and computes a Laplacian high-pass term.
- Applies runtime coring, gain and clip to that term, then adds it back to the centre pixel with saturation.
- Adds frame-synchronous shadowed configuration, a bypass mode, and border detection via row/column counters. U and V are delay-matched.

---
 rtl/isp_pkg.sv | 21 ++
 rtl/isp_ee_core.sv | 73 +++++++
 rtl/shift_register.sv | 22 ++
 rtl/isp_ee_v2.sv | 132 +++++++++++++
 tb/tb_isp_ee_v2.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/isp_pkg.sv
// Shared constants and saturating helpers for the ISP lite pipeline blocks.
package isp_pkg;

    localparam int unsigned GAIN_FRAC = 4;
    localparam int unsigned LAT       = 7;

    function automatic int sat_u(input int x, input int unsigned bits);
        int maxv;
        maxv = (1 << bits) - 1;
        if (x < 0) return 0;
        if (x > maxv) return maxv;
        return x;
    endfunction

    function automatic int clamp_s(input int x, input int lim);
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

endpackage

// File: rtl/isp_ee_core.sv
// Edge-enhance arithmetic: 3x3 window -> Laplacian, coring, gain, clip, saturating add.
module isp_ee_core
    import isp_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned GAIN_BITS = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [8:0][BITS-1:0]      win_i,
    input  logic [GAIN_BITS-1:0]      gain_i,
    input  logic [BITS-1:0]           thr_i,
    input  logic [BITS-1:0]           clip_i,
    output logic [BITS-1:0]           y_o
);

    localparam int unsigned SUM_W = BITS + 3;
    localparam int unsigned LAP_W = BITS + 5;
    localparam int unsigned COR_W = BITS + 2;
    localparam int unsigned MUL_W = BITS + GAIN_BITS + 2;

    logic [BITS-1:0]          cen2_q, cen3_q, cen4_q, cen5_q;
    logic [SUM_W-1:0]         sum2_d, sum2_q;
    logic signed [LAP_W-1:0]  lap, hp, thr_s, cor;
    logic signed [COR_W-1:0]  c3_d, c3_q;
    logic signed [MUL_W-1:0]  prod, m4_d, m4_q;
    logic signed [COR_W-1:0]  e5_d, e5_q;
    logic [BITS-1:0]          y6_d, y6_q;

    // Window index is row*3+col; index 4 is the centre pixel.
    always_comb begin
        sum2_d = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (i != 4) sum2_d = sum2_d + SUM_W'(win_i[i]);
        end
    end

    always_comb begin
        thr_s = LAP_W'(thr_i);
        lap   = LAP_W'({cen2_q, 3'b000}) - LAP_W'(sum2_q);
        hp    = lap >>> 3;
        if (hp > thr_s)       cor = hp - thr_s;
        else if (hp < -thr_s) cor = hp + thr_s;
        else                  cor = '0;
        c3_d  = COR_W'(cor);
    end

    always_comb begin
        prod = MUL_W'(c3_q) * MUL_W'($signed({1'b0, gain_i}));
        m4_d = prod >>> GAIN_FRAC;
        e5_d = COR_W'(clamp_s(int'(m4_q), int'(clip_i)));
        y6_d = BITS'(sat_u(int'(cen5_q) + int'(e5_q), BITS));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cen2_q <= '0; sum2_q <= '0;
            cen3_q <= '0; c3_q   <= '0;
            cen4_q <= '0; m4_q   <= '0;
            cen5_q <= '0; e5_q   <= '0;
            y6_q   <= '0;
        end else begin
            cen2_q <= win_i[4]; sum2_q <= sum2_d;
            cen3_q <= cen2_q;   c3_q   <= c3_d;
            cen4_q <= cen3_q;   m4_q   <= m4_d;
            cen5_q <= cen4_q;   e5_q   <= e5_d;
            y6_q   <= y6_d;
        end
    end

    assign y_o = y6_q;

endmodule

// File: rtl/shift_register.sv
// Enable-gated shift register without reset; q_o is the sample pushed DEPTH enables ago.
module shift_register #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q <= {mem_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = mem_q[DEPTH-1];

endmodule

// File: rtl/isp_ee_v2.sv
// Luma edge enhancer: line-buffered 3x3 window, frame-shadowed config, border/bypass
// passthrough, U/V and sync delay-matched to the 7-cycle luma pipeline.
module isp_ee_v2
    import isp_pkg::*;
#(
    parameter int unsigned BITS      = 8,
    parameter int unsigned WIDTH     = 1280,
    parameter int unsigned HEIGHT    = 960,
    parameter int unsigned GAIN_BITS = 8
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 in_href,
    input  logic                 in_vsync,
    input  logic [BITS-1:0]      in_y,
    input  logic [BITS-1:0]      in_u,
    input  logic [BITS-1:0]      in_v,
    input  logic                 cfg_en,
    input  logic [GAIN_BITS-1:0] cfg_gain,
    input  logic [BITS-1:0]      cfg_thr,
    input  logic [BITS-1:0]      cfg_clip,
    output logic                 out_href,
    output logic                 out_vsync,
    output logic [BITS-1:0]      out_y,
    output logic [BITS-1:0]      out_u,
    output logic [BITS-1:0]      out_v
);

    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);
    localparam int unsigned DL    = LAT - 1;

    logic                       vs_prev_q, href_prev_q, vs_rise, href_fall;
    logic [COL_W-1:0]           col_d, col_q;
    logic [ROW_W-1:0]           row_d, row_q;
    logic                       en_sh_q;
    logic [GAIN_BITS-1:0]       gain_sh_q;
    logic [BITS-1:0]            thr_sh_q, clip_sh_q;
    logic [BITS-1:0]            tap1, tap2, core_y;
    logic [8:0][BITS-1:0]       win_d, win_q;
    logic                       win_valid;
    logic [DL-1:0]              href_dq, vs_dq, enh_dq;
    logic [DL-1:0][BITS-1:0]    y_dq, u_dq, v_dq;
    logic                       out_href_q, out_vsync_q;
    logic [BITS-1:0]            out_y_d, out_y_q, out_u_q, out_v_q;

    assign vs_rise   = in_vsync & ~vs_prev_q;
    assign href_fall = href_prev_q & ~in_href;
    assign win_valid = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    always_comb begin
        col_d = '0;
        if (in_href) col_d = (col_q == COL_W'(WIDTH - 1)) ? col_q : col_q + COL_W'(1);
        row_d = row_q;
        if (vs_rise) row_d = '0;
        else if (href_fall && row_q != ROW_W'(HEIGHT - 1)) row_d = row_q + ROW_W'(1);
    end

    shift_register #(.DATA_W(BITS), .DEPTH(WIDTH)) u_lb0 (
        .clk_i(pclk), .en_i(in_href), .d_i(in_y), .q_o(tap1)
    );
    shift_register #(.DATA_W(BITS), .DEPTH(WIDTH)) u_lb1 (
        .clk_i(pclk), .en_i(in_href), .d_i(tap1), .q_o(tap2)
    );

    // Columns shift left; the newest column holds rows r-2, r-1, r from the line-buffer taps.
    always_comb begin
        win_d = win_q;
        if (in_href) begin
            for (int unsigned r = 0; r < 3; r++) begin
                win_d[r*3]   = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = tap2;
            win_d[5] = tap1;
            win_d[8] = in_y;
        end
    end

    isp_ee_core #(.BITS(BITS), .GAIN_BITS(GAIN_BITS)) u_core (
        .clk_i(pclk), .rst_i(rst), .win_i(win_q),
        .gain_i(gain_sh_q), .thr_i(thr_sh_q), .clip_i(clip_sh_q), .y_o(core_y)
    );

    always_comb begin
        out_y_d = '0;
        if (href_dq[DL-1]) out_y_d = enh_dq[DL-1] ? core_y : y_dq[DL-1];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0; href_prev_q <= 1'b0;
            col_q <= '0; row_q <= '0;
            en_sh_q <= 1'b0; gain_sh_q <= '0; thr_sh_q <= '0; clip_sh_q <= '0;
            win_q <= '0;
            href_dq <= '0; vs_dq <= '0; enh_dq <= '0;
            y_dq <= '0; u_dq <= '0; v_dq <= '0;
            out_href_q <= 1'b0; out_vsync_q <= 1'b0;
            out_y_q <= '0; out_u_q <= '0; out_v_q <= '0;
        end else begin
            vs_prev_q   <= in_vsync;
            href_prev_q <= in_href;
            col_q       <= col_d;
            row_q       <= row_d;
            if (vs_rise) begin
                en_sh_q   <= cfg_en;
                gain_sh_q <= cfg_gain;
                thr_sh_q  <= cfg_thr;
                clip_sh_q <= cfg_clip;
            end
            win_q   <= win_d;
            href_dq <= {href_dq[DL-2:0], in_href};
            vs_dq   <= {vs_dq[DL-2:0], in_vsync};
            enh_dq  <= {enh_dq[DL-2:0], en_sh_q & win_valid};
            y_dq    <= {y_dq[DL-2:0], in_y};
            u_dq    <= {u_dq[DL-2:0], in_u};
            v_dq    <= {v_dq[DL-2:0], in_v};
            out_href_q  <= href_dq[DL-1];
            out_vsync_q <= vs_dq[DL-1];
            out_y_q     <= out_y_d;
            out_u_q     <= href_dq[DL-1] ? u_dq[DL-1] : '0;
            out_v_q     <= href_dq[DL-1] ? v_dq[DL-1] : '0;
        end
    end

    assign out_href  = out_href_q;
    assign out_vsync = out_vsync_q;
    assign out_y     = out_y_q;
    assign out_u     = out_u_q;
    assign out_v     = out_v_q;

endmodule

// File: tb/tb_isp_ee_v2.sv
// Directed frames on an 8x6 image: flat, single bright pixel under several configs, bypass, reset.
module tb_isp_ee_v2;

    localparam int BITS = 8;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int BR   = 3;
    localparam int BC   = 3;

    logic       pclk = 1'b0;
    logic       rst;
    logic       in_href, in_vsync;
    logic [7:0] in_y, in_u, in_v;
    logic       cfg_en;
    logic [7:0] cfg_gain, cfg_thr, cfg_clip;
    logic       out_href, out_vsync;
    logic [7:0] out_y, out_u, out_v;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_pix;
    logic [23:0] expq[$];
    logic [23:0] mon_e;
    logic [6:0]  hist_h, hist_v;
    bit          mon_en = 1'b0;

    always #5 pclk = ~pclk;

    isp_ee_v2 #(.BITS(BITS), .WIDTH(W), .HEIGHT(H), .GAIN_BITS(8)) dut (
        .pclk(pclk), .rst(rst), .in_href(in_href), .in_vsync(in_vsync),
        .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .cfg_en(cfg_en), .cfg_gain(cfg_gain), .cfg_thr(cfg_thr), .cfg_clip(cfg_clip),
        .out_href(out_href), .out_vsync(out_vsync),
        .out_y(out_y), .out_u(out_u), .out_v(out_v)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge pclk) begin
        if (rst) begin
            hist_h <= '0;
            hist_v <= '0;
            expq.delete();
        end else begin
            hist_h <= {hist_h[5:0], in_href};
            hist_v <= {hist_v[5:0], in_vsync};
            if (in_href) expq.push_back(exp_pix);
        end
    end

    always @(negedge pclk) begin
        if (mon_en) begin
            check("out_href", int'(out_href), int'(hist_h[6]));
            check("out_vsync", int'(out_vsync), int'(hist_v[6]));
            if (out_href) begin
                check("pix_avail", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    mon_e = expq.pop_front();
                    check("out_y", int'(out_y), int'(mon_e[23:16]));
                    check("out_u", int'(out_u), int'(mon_e[15:8]));
                    check("out_v", int'(out_v), int'(mon_e[7:0]));
                end
            end else begin
                check("gate", int'({out_y, out_u, out_v}), 0);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        in_href = 1'b0;
        in_y = 8'd55; in_u = 8'd66; in_v = 8'd77;
        exp_pix = '0;
        repeat (n) tick();
    endtask

    function automatic int img(input bit bright, input int r, input int c);
        return (bright && r == BR && c == BC) ? 200 : 100;
    endfunction

    // ec/en: hand-computed enhanced values at the bright centre and its 8 neighbours.
    function automatic int exp_y(input bit bright, input int r, input int c,
                                 input int ec, input int en, input bit byp);
        int cr, cc;
        if (byp || r < 2 || c < 2) return img(bright, r, c);
        cr = r - 1;
        cc = c - 1;
        if (!bright) return 100;
        if (cr == BR && cc == BC) return ec;
        if (cr >= BR-1 && cr <= BR+1 && cc >= BC-1 && cc <= BC+1) return en;
        return 100;
    endfunction

    task automatic drive_pix(input bit bright, input int r, input int c,
                             input int ec, input int en, input bit byp);
        in_href = 1'b1;
        in_y = 8'(img(bright, r, c));
        in_u = 8'(r*16 + c + 1);
        in_v = 8'(255 - r*8 - c);
        exp_pix = {8'(exp_y(bright, r, c, ec, en, byp)), in_u, in_v};
    endtask

    task automatic set_cfg(input logic e, input logic [7:0] g, input logic [7:0] t, input logic [7:0] cl);
        cfg_en = e; cfg_gain = g; cfg_thr = t; cfg_clip = cl;
    endtask

    task automatic send_frame(input bit bright, input bit do_vs, input int ec, input int en,
                              input bit byp, input bit chg, input logic ne,
                              input logic [7:0] ng, input logic [7:0] nt, input logic [7:0] ncl);
        if (do_vs) begin
            in_vsync = 1'b1;
            idle(2);
            in_vsync = 1'b0;
        end
        idle(3);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_pix(bright, r, c, ec, en, byp);
                tick();
            end
            idle(4);
            if (chg && r == 2) set_cfg(ne, ng, nt, ncl);
        end
        idle(10);
    endtask

    initial begin
        rst = 1'b1;
        in_href = 1'b0; in_vsync = 1'b0;
        in_y = '0; in_u = '0; in_v = '0;
        exp_pix = '0;
        set_cfg(1'b1, 8'h10, 8'd0, 8'd255);
        repeat (2) @(posedge pclk);
        #1;
        check("reset out_href", int'(out_href), 0);
        check("reset out_vsync", int'(out_vsync), 0);
        check("reset out_y", int'(out_y), 0);
        check("reset out_u", int'(out_u), 0);
        check("reset out_v", int'(out_v), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(3);

        // flat 100, then bright pixel under B/C/D configs (each captured one frame after being set), then bypass
        send_frame(1'b0, 1'b1, 100, 100, 1'b0, 1'b1, 1'b1, 8'h10, 8'd0,  8'd255);
        send_frame(1'b1, 1'b1, 255, 87,  1'b0, 1'b1, 1'b1, 8'h10, 8'd20, 8'd255);
        send_frame(1'b1, 1'b1, 255, 100, 1'b0, 1'b1, 1'b1, 8'h08, 8'd0,  8'd30);
        send_frame(1'b1, 1'b1, 230, 93,  1'b0, 1'b1, 1'b0, 8'h08, 8'd0,  8'd30);
        send_frame(1'b1, 1'b1, 0,   0,   1'b1, 1'b0, 1'b0, 8'h00, 8'd0,  8'd0);

        // reset while a line is streaming
        set_cfg(1'b1, 8'h10, 8'd0, 8'd255);
        in_vsync = 1'b1;
        idle(2);
        in_vsync = 1'b0;
        idle(3);
        for (int c = 0; c < W - 1; c++) begin
            drive_pix(1'b0, 0, c, 100, 100, 1'b0);
            tick();
        end
        drive_pix(1'b0, 0, W - 1, 100, 100, 1'b0);
        check("pre-reset out_href", int'(out_href), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async rst out_href", int'(out_href), 0);
        check("async rst out_vsync", int'(out_vsync), 0);
        check("async rst out_y", int'(out_y), 0);
        check("async rst out_u", int'(out_u), 0);
        check("async rst out_v", int'(out_v), 0);
        idle(2);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(3);

        // no vsync since reset: shadow enable is still clear, so everything passes through
        send_frame(1'b1, 1'b0, 0,   0,  1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0);
        send_frame(1'b1, 1'b1, 255, 87, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0);

        check("drain", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
